// File: rtl/reset_sequencer.sv
// reset_sequencer: holds selected channels in reset, then releases them one at a time in ascending order
module reset_sequencer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cfg_hold,
  input  logic [CNT_W-1:0]  cfg_gap,
  input  logic [NUM_CH-1:0] rst_req,
  output logic [NUM_CH-1:0] reset_n,
  output logic              busy,
  output logic              seq_done
);
  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} state_t;
  state_t state, state_nx;
  logic [NUM_CH-1:0] act, act_nx, rn_nx, low;
  logic [CNT_W-1:0] cnt, cnt_nx, hold_l, gap_l, hold_lim;
  logic first, req, tick, done_nx;
  assign req = |rst_req;
  assign low = act & (~act + NUM_CH'(1));
  assign hold_lim = hold_l == '0 ? '0 : hold_l - CNT_W'(1);
  assign tick = cnt == (state == ASSERT ? hold_lim : gap_l);
  // the first edge after block reset acts as the accept edge, so the hold is counted from it
  always_comb begin
    state_nx = state;
    act_nx = act;
    rn_nx = reset_n;
    cnt_nx = cnt + CNT_W'(1);
    done_nx = 1'b0;
    if (req) begin
      act_nx = act | rst_req;
      rn_nx = reset_n & ~rst_req;
      cnt_nx = '0;
      state_nx = ASSERT;
    end else if (state == IDLE) begin
      cnt_nx = cnt;
    end else if (first) begin
      cnt_nx = '0;
    end else if (tick) begin
      act_nx = act & ~low;
      rn_nx = reset_n | low;
      cnt_nx = '0;
      state_nx = act_nx == '0 ? IDLE : RELEASE;
      done_nx = act_nx == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ASSERT;
      act <= '1;
      cnt <= '0;
      reset_n <= '0;
      busy <= 1'b1;
      seq_done <= 1'b0;
      first <= 1'b1;
      hold_l <= cfg_hold;
      gap_l <= cfg_gap;
    end else begin
      state <= state_nx;
      act <= act_nx;
      cnt <= cnt_nx;
      reset_n <= rn_nx;
      busy <= state_nx != IDLE;
      seq_done <= done_nx;
      first <= 1'b0;
      if (req) begin
        hold_l <= cfg_hold;
        gap_l <= cfg_gap;
      end
    end
  end
endmodule
